sar_search: RTL and testbench

SAR_SEARCH -- requirements
Module: sar_search

---
 rtl/sar_search.sv | 112 +++++++++++
 tb/tb_sar_search.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/sar_search.sv
// sar_search: successive-approximation search over an external comparator.
// Drives a registered trial value, resolves one bit per TEST cycle from
// the comparator's gt/lt/eq code, and pulses done with the result.
// Optional build macro: SAR_ERRCHK_EN (flag non-one-hot comparator codes).
module sar_search #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             gt,
    input  logic             lt,
    input  logic             eq,
    output logic [WIDTH-1:0] trial,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             found,
    output logic             err
);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, TEST, DONE} state_t;

    state_t           state, state_nxt;
    logic [IW-1:0]    idx, idx_nxt;
    logic [WIDTH-1:0] trial_nxt, result_nxt, upd, step;
    logic             found_nxt, err_q, err_nxt, bad_code;

`ifdef SAR_ERRCHK_EN
    // Valid comparator codes are exactly one-hot over {gt, lt, eq}
    assign bad_code = !((gt ^ lt ^ eq) && !(gt && lt && eq));
`else
    // No checking: overlapping codes resolve by priority eq > lt > gt
    assign bad_code = 1'b0;
`endif

    assign busy = (state == TEST);
    assign done = (state == DONE);
    assign err  = err_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state and datapath update; result/found/err only move on DONE entry
    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx;
        trial_nxt  = trial;
        result_nxt = result;
        found_nxt  = found;
        err_nxt    = err_q;
        // Resolve the bit under test: lt clears it, gt (or no code) keeps it
        upd        = trial;
        if (lt && !eq) upd[idx] = 1'b0;
        step       = upd;
        case (state)
            IDLE: begin
                if (start) begin
                    trial_nxt = {1'b1, {(WIDTH-1){1'b0}}};
                    idx_nxt   = IW'(WIDTH - 1);
                    state_nxt = TEST;
                end
            end
            TEST: begin
                if (bad_code) begin
                    err_nxt    = 1'b1;
                    result_nxt = trial;
                    found_nxt  = 1'b0;
                    state_nxt  = DONE;
                end else if (eq) begin
                    err_nxt    = 1'b0;
                    result_nxt = trial;
                    found_nxt  = 1'b1;
                    state_nxt  = DONE;
                end else if (idx == '0) begin
                    err_nxt    = 1'b0;
                    trial_nxt  = upd;
                    result_nxt = upd;
                    found_nxt  = 1'b0;
                    state_nxt  = DONE;
                end else begin
                    step[idx - 1'b1] = 1'b1;
                    trial_nxt        = step;
                    idx_nxt          = idx - 1'b1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trial  <= '0;
            idx    <= IW'(WIDTH - 1);
            result <= '0;
            found  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            trial  <= trial_nxt;
            idx    <= idx_nxt;
            result <= result_nxt;
            found  <= found_nxt;
            err_q  <= err_nxt;
        end
    end
endmodule

// File: tb/tb_sar_search.sv
// tb_sar_search: scoreboard bench for sar_search with a behavioural comparator.
module tb_sar_search;
    localparam int W = 4;

    typedef struct {
        int res;
        int fnd;
        int er;
        int cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         gt, lt, eq;
    logic [W-1:0] trial, result;
    logic         busy, done, found, err;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   cur_u = 0;
    bit   bad = 1'b0;
    int   tq[$];
    exp_t sq[$];
    exp_t m_e;
    int   m_t;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Ideal comparator against the unknown, optionally forced to an illegal code
    always_comb begin
        if (bad) begin
            gt = 1'b1; lt = 1'b1; eq = 1'b0;
        end else begin
            gt = (cur_u > int'(trial));
            lt = (cur_u < int'(trial));
            eq = (cur_u == int'(trial));
        end
    end

    sar_search #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .gt(gt), .lt(lt), .eq(eq),
        .trial(trial), .busy(busy), .done(done), .result(result),
        .found(found), .err(err)
    );

    task automatic chk(input string nm, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at t=%0t", nm, act, exp_v, $time);
        end
    endtask

    // Number of TEST cycles: search stops on the lowest set bit of the unknown
    function automatic int num_steps(input int u);
        if (u == 0) return W;
        for (int i = 0; i < W; i++) if (u[i]) return W - i;
        return W;
    endfunction

    task automatic expect_search(input int u, input bit badc, input int c);
        exp_t e;
`ifdef SAR_ERRCHK_EN
        if (badc) begin
            tq.push_back(1 << (W-1));
            e = '{1 << (W-1), 0, 1, c + 2};
            sq.push_back(e);
            return;
        end
`endif
        // Trial i = bits of u above i, then a 1 at i; stop when it hits u
        for (int i = W-1; i >= 0; i--) begin
            int t;
            t = (u & ~((1 << (i+1)) - 1)) | (1 << i);
            tq.push_back(t);
            if (t == u) break;
        end
        e = '{u, (u != 0) ? 1 : 0, 0, c + 1 + num_steps(u)};
        sq.push_back(e);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while ((busy || done) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (busy || done) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout actual=busy%0d/done%0d expected=idle", busy, done);
        end
    endtask

    task automatic run(input int u, input bit badc, input bit mid);
        wait_idle();
        cur_u = u;
        bad   = badc;
        expect_search(u, badc, cyc);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (badc) begin
            @(negedge clk);
            bad = 1'b0;
        end
        if (mid) begin
            @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    // Monitor: trial during TEST and the done payload against the queues
    always @(negedge clk) begin
        if (rst_n) begin
            if (busy) begin
                if (tq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL trial_extra actual=%0d expected=none", trial);
                end else begin
                    m_t = tq.pop_front();
                    chk("trial", int'(trial), m_t);
                end
            end
            if (done) begin
                if (sq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done actual=1 expected=0 result=%0d", result);
                end else begin
                    m_e = sq.pop_front();
                    chk("result", int'(result), m_e.res);
                    chk("found", int'(found), m_e.fnd);
                    chk("err", int'(err), m_e.er);
                    chk("latency", cyc, m_e.cyc);
                end
            end
        end
    end

    initial begin
        // Reset state
        #3;
        chk("rst_trial", int'(trial), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_result", int'(result), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed: first-trial hit, full search, lower and upper boundary
        run(8, 1'b0, 1'b0);
        run(5, 1'b0, 1'b0);
        run(0, 1'b0, 1'b0);
        run(15, 1'b0, 1'b0);
        run(3, 1'b0, 1'b0);   // starts the cycle after done

        // Reset during the second TEST cycle aborts with no done
        wait_idle();
        cur_u = 10;
        tq.push_back(8);
        tq.push_back(12);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_trial", int'(trial), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_result", int'(result), 0);
        chk("abort_found", int'(found), 0);
        chk("abort_err", int'(err), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("post_rst_busy", int'(busy), 0);
        chk("post_rst_trials", tq.size(), 0);

        // start pulsed mid-search is ignored
        run(5, 1'b0, 1'b1);
        // Illegal gt=lt=1 code in the first TEST cycle
        run(3, 1'b1, 1'b0);

        // Random unknowns with random idle gaps
        repeat (24) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run(int'($urandom_range(0, (1 << W) - 1)), 1'b0, 1'b0);
        end

        wait_idle();
        repeat (2) @(negedge clk);
        chk("drain_done", sq.size(), 0);
        chk("drain_trial", tq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
